uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arb
// Packet-level round-robin arbiter sharing one UART Tx FIFO among 3 requesters.
// Rev    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [2:0]  iReq_Valid,
    input  logic [23:0] iReq_Data,
    input  logic [2:0]  iReq_Last,
    output logic [2:0]  oReq_Ready,
    input  logic        iTx_Full,
    output logic        oPush,
    output logic [7:0]  oAscii,
    output logic [2:0]  oGrant,
    output logic        oBusy,
    output logic        oTimeout
);

    // Revoke fires on the idle cycle whose increment would make the counter reach TIMEOUT_CYC.
    localparam logic [15:0] c_to_last = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_grant, w_grant_nxt, w_rr_pick;
    logic [1:0]  r_last_owner, w_last_owner_nxt, w_owner_idx;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic        w_owner_valid, w_owner_last, w_push, w_timeout;

    // Grant is all-zero outside XFER, so every grant-masked output is quiet in IDLE and reset.
    assign w_owner_valid = |(iReq_Valid & r_grant);
    assign w_owner_last  = |(iReq_Last & r_grant);
    assign oReq_Ready    = r_grant & {3{~iTx_Full}};
    assign w_push        = |(iReq_Valid & oReq_Ready);
    assign w_timeout     = (r_state == XFER) && !w_owner_valid && !iTx_Full && (r_cnt == c_to_last);
    assign w_owner_idx   = r_grant[2] ? 2'd2 : (r_grant[1] ? 2'd1 : 2'd0);

    assign oPush    = w_push;
    assign oGrant   = r_grant;
    assign oBusy    = (r_state == XFER);
    assign oTimeout = w_timeout;
    assign oAscii   = ({8{r_grant[0]}} & iReq_Data[7:0])
                    | ({8{r_grant[1]}} & iReq_Data[15:8])
                    | ({8{r_grant[2]}} & iReq_Data[23:16]);

    always_comb begin
        w_rr_pick = 3'b000;
        case (r_last_owner)
            2'd0: begin
                if      (iReq_Valid[1]) w_rr_pick = 3'b010;
                else if (iReq_Valid[2]) w_rr_pick = 3'b100;
                else if (iReq_Valid[0]) w_rr_pick = 3'b001;
            end
            2'd1: begin
                if      (iReq_Valid[2]) w_rr_pick = 3'b100;
                else if (iReq_Valid[0]) w_rr_pick = 3'b001;
                else if (iReq_Valid[1]) w_rr_pick = 3'b010;
            end
            default: begin
                if      (iReq_Valid[0]) w_rr_pick = 3'b001;
                else if (iReq_Valid[1]) w_rr_pick = 3'b010;
                else if (iReq_Valid[2]) w_rr_pick = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        case (r_state)
            IDLE: begin
                if (|iReq_Valid) begin
                    w_state_nxt = XFER;
                    w_grant_nxt = w_rr_pick;
                    w_cnt_nxt   = 16'd0;
                end
            end
            XFER: begin
                if (w_push) begin
                    w_cnt_nxt = 16'd0;
                    if (w_owner_last) begin
                        w_state_nxt      = IDLE;
                        w_grant_nxt      = 3'b000;
                        w_last_owner_nxt = w_owner_idx;
                    end
                end else if (w_timeout) begin
                    w_state_nxt      = IDLE;
                    w_grant_nxt      = 3'b000;
                    w_last_owner_nxt = w_owner_idx;
                end else if (!w_owner_valid && !iTx_Full) begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 3'b000;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state      <= IDLE;
            r_grant      <= 3'b000;
            r_last_owner <= 2'd2;
            r_cnt        <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire
